// File: rtl/fp_pkg.sv
// Shared binary32 constants and state encoding for the floating-point
// adder datapath (normalize/round stage and the multiplier rounding path).
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int SIG_W  = 28;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   // Bit positions inside the 28-bit working significand.
   localparam int CARRY  = 27;
   localparam int HIDDEN = 26;
   localparam int LSB    = 3;
   localparam int G      = 2;
   localparam int R      = 1;
   localparam int S      = 0;

   // Wide exponent used internally so that 254+1 or 255+1 does not wrap.
   localparam int EXP_IW = EXP_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NORM  = 3'd1,
      ST_ROUND = 3'd2,
      ST_PACK  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Assemble a binary32 word from its three fields.
   function automatic logic [31:0] pack_word(input logic             sign,
                                             input logic [EXP_W-1:0] exp,
                                             input logic [FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

   // Signed zero with the given sign.
   function automatic logic [31:0] signed_zero(input logic sign);
      return {sign, 31'b0};
   endfunction

   // Signed infinity with the given sign.
   function automatic logic [31:0] signed_inf(input logic sign);
      return {sign, EXP_MAX, {FRAC_W{1'b0}}};
   endfunction

endpackage

// File: rtl/fp_normalize_round_if.sv
// Request/result bundle between the adder control unit and the
// normalize-and-round stage. The master issues a raw sum, the slave
// returns the packed binary32 result with status flags.
interface fp_normalize_round_if;
   import fp_pkg::*;

   logic                 start;
   logic                 in_sign;
   logic [EXP_W-1:0]     in_exp;
   logic [SIG_W-1:0]     in_sig;
   logic                 busy;
   logic                 done;
   logic [31:0]          result;
   logic                 overflow;
   logic                 underflow;

   modport master (
      output start, in_sign, in_exp, in_sig,
      input  busy, done, result, overflow, underflow
   );

   modport slave (
      input  start, in_sign, in_exp, in_sig,
      output busy, done, result, overflow, underflow
   );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a 28-bit working significand.
// Rounds at bit 3 using guard/round/sticky in bits [2:0], clears them,
// and reports whether the increment rippled into the carry position.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [SIG_W-1:0] sig_i,
   output logic [SIG_W-1:0] sig_o,
   output logic             carry_o
);

   logic                 round_up;
   logic [SIG_W-LSB-1:0] upper;

   // Increment the kept bits when above half, or exactly half with odd LSB.
   always_comb begin
      round_up = sig_i[G] & (sig_i[R] | sig_i[S] | sig_i[LSB]);
      upper    = sig_i[SIG_W-1:LSB] + {{(SIG_W-LSB-1){1'b0}}, round_up};
      sig_o    = {upper, 3'b000};
      carry_o  = upper[CARRY-LSB];
   end

endmodule

// File: rtl/fp_normalize_round.sv
// Sequential normalize-and-round stage of the binary32 adder. Takes the
// raw signed-magnitude sum, shifts it to normalized form one bit per
// cycle, rounds to nearest-even (renormalizing on carry-out) and packs
// the result. Subnormal results are flushed to signed zero.
module fp_normalize_round
   import fp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   fp_normalize_round_if.slave   bus
);

   state_t              state_q, state_d;
   logic                sign_q, sign_d;
   logic [EXP_IW-1:0]   exp_q, exp_d;
   logic [SIG_W-1:0]    sig_q, sig_d;
   logic [31:0]         result_q, result_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                done_q;

   logic [SIG_W-1:0]    rnd_sig;
   logic                rnd_carry;

   fp_round_rne u_round (
      .sig_i   (sig_q),
      .sig_o   (rnd_sig),
      .carry_o (rnd_carry)
   );

   // State and datapath registers; done is a registered echo of DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         sig_q       <= '0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         sig_q       <= sig_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         done_q      <= (state_q == ST_DONE);
      end
   end

   // Next-state and datapath update for each phase of the operation.
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      sig_d       = sig_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sign_d      = bus.in_sign;
               exp_d       = {1'b0, bus.in_exp};
               sig_d       = bus.in_sig;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
               state_d     = ST_NORM;
            end
         end

         ST_NORM: begin
            if (sig_q == '0) begin
               // Exact cancellation: signed zero, not an underflow.
               result_d    = signed_zero(sign_q);
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
               state_d     = ST_DONE;
            end else if (sig_q[CARRY]) begin
               // Carry out of the adder: one right shift, fold the lost bit into sticky.
               sig_d   = {1'b0, sig_q[CARRY:2], sig_q[R] | sig_q[S]};
               exp_d   = exp_q + 9'd1;
               state_d = ST_ROUND;
            end else if (sig_q[HIDDEN]) begin
               state_d = ST_ROUND;
            end else if (exp_q <= 9'd1) begin
               // Another left shift would need a subnormal exponent: flush.
               result_d    = signed_zero(sign_q);
               underflow_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               sig_d = {sig_q[SIG_W-2:0], 1'b0};
               exp_d = exp_q - 9'd1;
            end
         end

         ST_ROUND: begin
            // A carry-out goes back through NORM for a single right shift;
            // guard is then zero so the following round cannot increment again.
            sig_d   = rnd_sig;
            state_d = rnd_carry ? ST_NORM : ST_PACK;
         end

         ST_PACK: begin
            if (exp_q >= {1'b0, EXP_MAX}) begin
               result_d   = signed_inf(sign_q);
               overflow_d = 1'b1;
            end else begin
               result_d = pack_word(sign_q, exp_q[EXP_W-1:0], sig_q[HIDDEN-1:LSB]);
            end
            state_d = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed and randomized checks of the normalize-and-round stage against
// an arithmetic reference model of the rounding rules and cycle counts.
module tb_fp_normalize_round;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fp_normalize_round_if bus ();

   fp_normalize_round dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value-level normalize, nearest-even rounding, and the
   // cycle count implied by one bit of shift per cycle.
   task automatic model(input logic s, input logic [7:0] e, input logic [27:0] sg,
                        output logic [31:0] res, output logic ovf, output logic unf,
                        output int n);
      int          p;
      int          k;
      int          ex;
      logic [27:0] m;
      logic [24:0] mant;
      logic [2:0]  rem;
      logic [31:0] exv;
      ovf = 1'b0;
      unf = 1'b0;
      res = {s, 31'b0};
      n   = 2;
      if (sg == 28'd0) return;
      p = 0;
      for (int i = 0; i < 28; i++) if (sg[i]) p = i;
      ex = int'(e);
      k  = 0;
      if (p == 27) begin
         m  = (sg >> 1) | {27'b0, sg[0]};
         ex = ex + 1;
      end else begin
         k = 26 - p;
         if (k > 0 && ex < k + 1) begin
            unf = 1'b1;
            n   = 2 + ((ex > 1) ? ex - 1 : 0);
            return;
         end
         m  = sg << k;
         ex = ex - k;
      end
      mant = {1'b0, m[26:3]};
      rem  = m[2:0];
      n    = 4 + k;
      if (rem > 3'd4 || (rem == 3'd4 && mant[0])) mant = mant + 25'd1;
      if (mant[24]) begin
         mant = mant >> 1;
         ex   = ex + 1;
         n    = n + 2;
      end
      exv = 32'(ex);
      if (ex >= 255) begin
         ovf = 1'b1;
         res = {s, 8'hFF, 23'b0};
      end else begin
         res = {s, exv[7:0], mant[22:0]};
      end
   endtask

   // Issue one operation, wait for done within a bound, check everything.
   // With inject set, a competing start is driven while the stage is busy.
   task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] sg, input bit inject);
      logic [31:0] exp_res;
      logic        exp_ovf;
      logic        exp_unf;
      int          exp_n;
      int          n;
      int          extra;
      bit          got;
      model(s, e, sg, exp_res, exp_ovf, exp_unf, exp_n);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.in_sign = s;
      bus.in_exp  = e;
      bus.in_sig  = sg;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      n   = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(posedge clk);
         n++;
         #1;
         if (inject && n == 2) begin
            bus.start   = 1'b1;
            bus.in_sign = ~s;
            bus.in_exp  = 8'd100;
            bus.in_sig  = 28'h8000000;
         end else if (inject && n == 3) begin
            bus.start = 1'b0;
         end
         if (bus.done) got = 1'b1;
      end
      bus.start = 1'b0;
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(n), 32'(exp_n));
      chk({tag, " result"}, bus.result, exp_res);
      chk({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
      chk({tag, " underflow"}, 32'(bus.underflow), 32'(exp_unf));
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, " result_held"}, bus.result, exp_res);
      if (inject) begin
         extra = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
         end
         chk({tag, " no_second_done"}, 32'(extra), 32'd0);
      end
      $display("op %s: sign=%0b exp=%0d sig=%h -> result=%h ovf=%0b unf=%0b cycles=%0d",
               tag, s, e, sg, bus.result, bus.overflow, bus.underflow, n);
   endtask

   initial begin
      logic [27:0] one;
      logic [27:0] rsig;
      logic [31:0] r32;
      logic [7:0]  rexp;
      int          p;
      int          dones;

      bus.start   = 1'b0;
      bus.in_sign = 1'b0;
      bus.in_exp  = 8'd0;
      bus.in_sig  = 28'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset result", bus.result, 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      run_op("one_plus_one", 1'b0, 8'd127, 28'h8000000, 1'b0);
      chk("one_plus_one literal", bus.result, 32'h40000000);
      run_op("two_lshift", 1'b0, 8'd130, 28'h1000000, 1'b0);
      chk("two_lshift literal", bus.result, 32'h40000000);
      run_op("tie_even_down", 1'b0, 8'd127, 28'h4000004, 1'b0);
      chk("tie_even_down literal", bus.result, 32'h3F800000);
      run_op("tie_odd_up", 1'b0, 8'd127, 28'h400000C, 1'b0);
      chk("tie_odd_up literal", bus.result, 32'h3F800002);
      run_op("round_carry", 1'b0, 8'd127, 28'h7FFFFFC, 1'b0);
      chk("round_carry literal", bus.result, 32'h40000000);
      run_op("overflow", 1'b0, 8'd254, 28'h8000000, 1'b0);
      chk("overflow literal", bus.result, 32'h7F800000);
      run_op("underflow", 1'b0, 8'd1, 28'h2000000, 1'b0);
      chk("underflow literal", bus.result, 32'h00000000);
      run_op("neg_zero", 1'b1, 8'd50, 28'h0000000, 1'b0);
      chk("neg_zero literal", bus.result, 32'h80000000);
      run_op("underflow_after_shifts", 1'b1, 8'd4, 28'h0000100, 1'b0);
      run_op("sticky_carry", 1'b1, 8'd10, 28'hC000005, 1'b0);

      // Competing start while busy is dropped
      run_op("busy_start", 1'b0, 8'd140, 28'h0400000, 1'b1);

      // Reset mid-way through a 20-shift normalization
      @(negedge clk);
      bus.start   = 1'b1;
      bus.in_sign = 1'b0;
      bus.in_exp  = 8'd100;
      bus.in_sig  = 28'h0000040;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("midrun busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrun reset result", bus.result, 32'd0);
      chk("midrun reset busy", 32'(bus.busy), 32'd0);
      chk("midrun reset done", 32'(bus.done), 32'd0);
      chk("midrun reset flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) dones++;
      end
      chk("midrun no_done", 32'(dones), 32'd0);
      chk("midrun result_zero", bus.result, 32'd0);
      $display("op midrun_reset: aborted 20-shift run, activity_after_reset=%0d", dones);

      // Randomized operations
      one = 28'd1;
      for (int t = 0; t < 40; t++) begin
         r32 = $urandom;
         p   = $urandom_range(0, 27);
         rsig = (one << p) | (r32[27:0] & ((one << p) - 28'd1));
         if ($urandom_range(0, 9) == 0) rsig = 28'd0;
         if ($urandom_range(0, 1) == 0) rexp = 8'($urandom_range(20, 235));
         else rexp = 8'($urandom_range(0, 255));
         run_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), rexp, rsig, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
